// File: rtl/ring_pkg.sv
// rtl/ring_pkg.sv - shared types and helpers for the ring slot monitor
package ring_pkg;

    localparam int RING_N_DEF = 3;
    localparam int RING_N_MAX = 32;

    typedef enum logic [1:0] {
        SYNC   = 2'd0,
        TRACK  = 2'd1,
        FAULT  = 2'd2,
        REINIT = 2'd3
    } mon_state_t;

    // Narrower ring vectors are zero-extended by the caller.
    function automatic logic is_onehot(input logic [RING_N_MAX-1:0] v);
        return (v != '0) && ((v & (v - RING_N_MAX'(1))) == '0);
    endfunction

    function automatic int rot_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/ring_slot_monitor_if.sv
// rtl/ring_slot_monitor_if.sv - ring sample in, slot index and status out
interface ring_slot_monitor_if #(
    parameter int N     = ring_pkg::RING_N_DEF,
    parameter int CNT_W = 8
);
    import ring_pkg::*;

    localparam int IDX_W = $clog2(N);

    logic [N-1:0]     ring_q;
    logic             err_clr;
    logic [IDX_W-1:0] slot_idx;
    logic             slot_valid;
    logic             wrap;
    logic [CNT_W-1:0] rot_count;
    logic             err;
    logic             reinit_n;

    modport master (
        output ring_q, err_clr,
        input  slot_idx, slot_valid, wrap, rot_count, err, reinit_n
    );

    modport slave (
        input  ring_q, err_clr,
        output slot_idx, slot_valid, wrap, rot_count, err, reinit_n
    );

endinterface

// File: rtl/onehot_enc.sv
// rtl/onehot_enc.sv - one-hot ring state to binary index plus legality flag
module onehot_enc
    import ring_pkg::*;
#(
    parameter  int N     = RING_N_DEF,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     ring_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             legal_o
);

    // Index is only meaningful when legal_o is set.
    always_comb begin
        idx_o = '0;
        for (int i = 0; i < N; i++) begin
            if (ring_i[i]) begin
                idx_o = IDX_W'(i);
            end
        end
    end

    assign legal_o = is_onehot(RING_N_MAX'(ring_i));

endmodule

// File: rtl/ring_slot_monitor.sv
// rtl/ring_slot_monitor.sv - tracks ring slot position, counts rotations, requests re-init on faults
module ring_slot_monitor
    import ring_pkg::*;
#(
    parameter int N             = RING_N_DEF,
    parameter int CNT_W         = 8,
    parameter int ERR_LIMIT     = 2,
    parameter int REINIT_CYCLES = 2
) (
    input logic                clk,
    input logic                ori,
    ring_slot_monitor_if.slave bus
);

    localparam int IDX_W = $clog2(N);
    localparam int BAD_W = $clog2(ERR_LIMIT + 1);
    localparam int RI_W  = $clog2(REINIT_CYCLES + 1);

    mon_state_t       state_q, state_d;
    logic [IDX_W-1:0] slot_idx_q, slot_idx_d;
    logic [IDX_W-1:0] expected_q, expected_d;
    logic             slot_valid_q, slot_valid_d;
    logic             wrap_q, wrap_d;
    logic [CNT_W-1:0] rot_count_q, rot_count_d;
    logic             err_q, err_d;
    logic             reinit_n_q, reinit_n_d;
    logic [BAD_W-1:0] bad_cnt_q, bad_cnt_d;
    logic [RI_W-1:0]  reinit_cnt_q, reinit_cnt_d;

    logic [IDX_W-1:0] enc_idx;
    logic             enc_legal;
    logic             good;
    logic             bad_limit;
    logic             reinit_done;

    onehot_enc #(.N(N)) u_enc (
        .ring_i  (bus.ring_q),
        .idx_o   (enc_idx),
        .legal_o (enc_legal)
    );

    assign good        = enc_legal && (enc_idx == expected_q);
    assign bad_limit   = (bad_cnt_q == BAD_W'(ERR_LIMIT - 1));
    assign reinit_done = (reinit_cnt_q == RI_W'(REINIT_CYCLES - 1));

    always_ff @(posedge clk or negedge ori) begin
        if (!ori) begin
            state_q      <= SYNC;
            slot_idx_q   <= '0;
            expected_q   <= '0;
            slot_valid_q <= 1'b0;
            wrap_q       <= 1'b0;
            rot_count_q  <= '0;
            err_q        <= 1'b0;
            reinit_n_q   <= 1'b1;
            bad_cnt_q    <= '0;
            reinit_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            slot_idx_q   <= slot_idx_d;
            expected_q   <= expected_d;
            slot_valid_q <= slot_valid_d;
            wrap_q       <= wrap_d;
            rot_count_q  <= rot_count_d;
            err_q        <= err_d;
            reinit_n_q   <= reinit_n_d;
            bad_cnt_q    <= bad_cnt_d;
            reinit_cnt_q <= reinit_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SYNC:    if (enc_legal) state_d = TRACK;
            TRACK:   if (!good && bad_limit) state_d = FAULT;
            FAULT:   state_d = REINIT;
            REINIT:  if (reinit_done) state_d = SYNC;
            default: state_d = SYNC;
        endcase
    end

    always_comb begin
        slot_idx_d   = slot_idx_q;
        expected_d   = expected_q;
        slot_valid_d = 1'b0;
        wrap_d       = 1'b0;
        rot_count_d  = rot_count_q;
        bad_cnt_d    = bad_cnt_q;
        reinit_cnt_d = '0;
        reinit_n_d   = (state_d != REINIT);
        err_d        = err_q & ~bus.err_clr;
        case (state_q)
            SYNC: begin
                if (enc_legal) begin
                    slot_idx_d   = enc_idx;
                    expected_d   = IDX_W'(rot_next(int'(enc_idx), N));
                    slot_valid_d = 1'b1;
                    bad_cnt_d    = '0;
                end
            end
            TRACK: begin
                // Expected position keeps advancing through bad samples so a
                // single glitch does not desynchronise the tracker.
                expected_d = IDX_W'(rot_next(int'(expected_q), N));
                if (good) begin
                    slot_idx_d   = enc_idx;
                    slot_valid_d = 1'b1;
                    bad_cnt_d    = '0;
                    if (enc_idx == '0 && slot_valid_q && slot_idx_q == IDX_W'(N - 1)) begin
                        wrap_d = 1'b1;
                        if (rot_count_q != '1) begin
                            rot_count_d = rot_count_q + CNT_W'(1);
                        end
                    end
                end else begin
                    bad_cnt_d = bad_cnt_q + BAD_W'(1);
                end
            end
            FAULT: begin
                err_d     = 1'b1;
                bad_cnt_d = '0;
            end
            REINIT: begin
                reinit_cnt_d = reinit_cnt_q + RI_W'(1);
            end
            default: begin
            end
        endcase
    end

    assign bus.slot_idx   = slot_idx_q;
    assign bus.slot_valid = slot_valid_q;
    assign bus.wrap       = wrap_q;
    assign bus.rot_count  = rot_count_q;
    assign bus.err        = err_q;
    assign bus.reinit_n   = reinit_n_q;

endmodule

// File: tb/tb_ring_slot_monitor.sv
// tb/tb_ring_slot_monitor.sv - directed self-checking bench for ring_slot_monitor
module tb_ring_slot_monitor;
    import ring_pkg::*;

    localparam int N     = 3;
    localparam int CNT_W = 8;
    localparam int SAT_W = 2;

    logic clk = 1'b0;
    logic ori;
    always #5 clk = ~clk;

    ring_slot_monitor_if #(.N(N), .CNT_W(CNT_W)) bus_m ();
    ring_slot_monitor_if #(.N(N), .CNT_W(SAT_W)) bus_s ();

    ring_slot_monitor #(.N(N), .CNT_W(CNT_W), .ERR_LIMIT(2), .REINIT_CYCLES(2)) dut (
        .clk (clk),
        .ori (ori),
        .bus (bus_m)
    );

    ring_slot_monitor #(.N(N), .CNT_W(SAT_W), .ERR_LIMIT(2), .REINIT_CYCLES(2)) dut_sat (
        .clk (clk),
        .ori (ori),
        .bus (bus_s)
    );

    int n_pass  = 0;
    int n_total = 0;

    // {slot_idx, slot_valid, wrap, rot_count, err, reinit_n}
    function automatic logic [13:0] obs_m();
        return {bus_m.slot_idx, bus_m.slot_valid, bus_m.wrap, bus_m.rot_count,
                bus_m.err, bus_m.reinit_n};
    endfunction

    function automatic logic [13:0] exp_m(int idx, int v, int w, int rot, int e, int r);
        return {2'(idx), 1'(v), 1'(w), 8'(rot), 1'(e), 1'(r)};
    endfunction

    function automatic logic [2:0] obs_s();
        return {bus_s.wrap, bus_s.rot_count};
    endfunction

    task automatic step(input logic [2:0] r, input logic clr);
        bus_m.ring_q  = r;
        bus_s.ring_q  = r;
        bus_m.err_clr = clr;
        bus_s.err_clr = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [13:0] e;
        ori = 1'b0;
        bus_m.ring_q = '0; bus_s.ring_q = '0;
        bus_m.err_clr = 1'b0; bus_s.err_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        e = exp_m(0, 0, 0, 0, 0, 1);
        if (obs_m() !== e) $display("FAIL reset_main got %h expected %h", obs_m(), e);
        else n_pass++;
        n_total++;
        if (obs_s() !== 3'b000) $display("FAIL reset_sat got %h expected %h", obs_s(), 3'b000);
        else n_pass++;
        n_total++;
        ori = 1'b1;
        step(3'b000, 1'b0);
        if (obs_m() !== e) $display("FAIL sync_zero got %h expected %h", obs_m(), e);
        else n_pass++;
        n_total++;
        step(3'b011, 1'b0);
        if (obs_m() !== e) $display("FAIL sync_illegal got %h expected %h", obs_m(), e);
        else n_pass++;
        n_total++;
    endtask

    task automatic test_clean_rotation();
        logic [2:0]  rs [0:9];
        logic [13:0] ex [0:9];
        rs = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001};
        ex = '{exp_m(0,1,0,0,0,1), exp_m(1,1,0,0,0,1), exp_m(2,1,0,0,0,1),
               exp_m(0,1,1,1,0,1), exp_m(1,1,0,1,0,1), exp_m(2,1,0,1,0,1),
               exp_m(0,1,1,2,0,1), exp_m(1,1,0,2,0,1), exp_m(2,1,0,2,0,1),
               exp_m(0,1,1,3,0,1)};
        for (int i = 0; i < 10; i++) begin
            step(rs[i], 1'b0);
            if (obs_m() !== ex[i]) $display("FAIL clean_rot step %0d got %h expected %h", i, obs_m(), ex[i]);
            else n_pass++;
            n_total++;
        end
    endtask

    task automatic test_illegal();
        logic [2:0]  rs [0:6];
        logic [13:0] ex [0:6];
        rs = '{3'b011, 3'b100, 3'b001, 3'b000, 3'b100, 3'b001, 3'b010};
        ex = '{exp_m(0,0,0,3,0,1), exp_m(2,1,0,3,0,1), exp_m(0,1,1,4,0,1),
               exp_m(0,0,0,4,0,1), exp_m(2,1,0,4,0,1), exp_m(0,1,1,5,0,1),
               exp_m(1,1,0,5,0,1)};
        for (int i = 0; i < 7; i++) begin
            step(rs[i], 1'b0);
            if (obs_m() !== ex[i]) $display("FAIL illegal step %0d got %h expected %h", i, obs_m(), ex[i]);
            else n_pass++;
            n_total++;
        end
    endtask

    task automatic test_stall();
        logic [2:0]  rs [0:5];
        logic [13:0] ex [0:5];
        rs = '{3'b010, 3'b010, 3'b100, 3'b001, 3'b001, 3'b001};
        ex = '{exp_m(1,0,0,5,0,1), exp_m(1,0,0,5,0,1), exp_m(1,0,0,5,1,0),
               exp_m(1,0,0,5,1,0), exp_m(1,0,0,5,1,1), exp_m(0,1,0,5,1,1)};
        for (int i = 0; i < 6; i++) begin
            step(rs[i], 1'b0);
            if (obs_m() !== ex[i]) $display("FAIL stall step %0d got %h expected %h", i, obs_m(), ex[i]);
            else n_pass++;
            n_total++;
        end
    endtask

    task automatic test_clear_collision();
        logic [2:0]  rs [0:5];
        logic        cl [0:5];
        logic [13:0] ex [0:5];
        rs = '{3'b010, 3'b010, 3'b010, 3'b100, 3'b100, 3'b100};
        cl = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        ex = '{exp_m(1,1,0,5,0,1), exp_m(1,0,0,5,0,1), exp_m(1,0,0,5,0,1),
               exp_m(1,0,0,5,1,0), exp_m(1,0,0,5,0,0), exp_m(1,0,0,5,0,1)};
        for (int i = 0; i < 6; i++) begin
            step(rs[i], cl[i]);
            if (obs_m() !== ex[i]) $display("FAIL clear step %0d got %h expected %h", i, obs_m(), ex[i]);
            else n_pass++;
            n_total++;
        end
    endtask

    task automatic test_reset_mid_reinit();
        logic [2:0]  rs [0:3];
        logic [13:0] ex [0:3];
        logic [2:0]  rr [0:2];
        logic [13:0] er [0:2];
        rs = '{3'b001, 3'b001, 3'b001, 3'b001};
        ex = '{exp_m(0,1,0,5,0,1), exp_m(0,0,0,5,0,1), exp_m(0,0,0,5,0,1),
               exp_m(0,0,0,5,1,0)};
        for (int i = 0; i < 4; i++) begin
            step(rs[i], 1'b0);
            if (obs_m() !== ex[i]) $display("FAIL pre_reset step %0d got %h expected %h", i, obs_m(), ex[i]);
            else n_pass++;
            n_total++;
        end
        ori = 1'b0;
        #1;
        if (obs_m() !== exp_m(0,0,0,0,0,1))
            $display("FAIL async_reset got %h expected %h", obs_m(), exp_m(0,0,0,0,0,1));
        else n_pass++;
        n_total++;
        if (obs_s() !== 3'b000) $display("FAIL async_reset_sat got %h expected %h", obs_s(), 3'b000);
        else n_pass++;
        n_total++;
        @(posedge clk);
        #1;
        ori = 1'b1;
        rr = '{3'b000, 3'b100, 3'b001};
        er = '{exp_m(0,0,0,0,0,1), exp_m(2,1,0,0,0,1), exp_m(0,1,1,1,0,1)};
        for (int i = 0; i < 3; i++) begin
            step(rr[i], 1'b0);
            if (obs_m() !== er[i]) $display("FAIL resync step %0d got %h expected %h", i, obs_m(), er[i]);
            else n_pass++;
            n_total++;
        end
    endtask

    task automatic test_saturation();
        logic [2:0] es;
        ori = 1'b0;
        @(posedge clk);
        #1;
        ori = 1'b1;
        step(3'b001, 1'b0);
        if (obs_m() !== exp_m(0,1,0,0,0,1))
            $display("FAIL sat_sync got %h expected %h", obs_m(), exp_m(0,1,0,0,0,1));
        else n_pass++;
        n_total++;
        for (int k = 1; k <= 5; k++) begin
            step(3'b010, 1'b0);
            es = {1'b0, 2'((k - 1 > 3) ? 3 : k - 1)};
            if (obs_s() !== es) $display("FAIL sat_mid rot %0d got %h expected %h", k, obs_s(), es);
            else n_pass++;
            n_total++;
            step(3'b100, 1'b0);
            step(3'b001, 1'b0);
            es = {1'b1, 2'((k > 3) ? 3 : k)};
            if (obs_s() !== es) $display("FAIL sat_wrap rot %0d got %h expected %h", k, obs_s(), es);
            else n_pass++;
            n_total++;
            if (obs_m() !== exp_m(0,1,1,k,0,1))
                $display("FAIL main_wrap rot %0d got %h expected %h", k, obs_m(), exp_m(0,1,1,k,0,1));
            else n_pass++;
            n_total++;
        end
    endtask

    initial begin
        test_reset();
        test_clean_rotation();
        test_illegal();
        test_stall();
        test_clear_collision();
        test_reset_mid_reinit();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
